// File: rtl/fft32_frame_sched.sv
`default_nettype none
// ============================================================================
// Module   : fft32_frame_sched
// Purpose  : Shares one FFT core between two sample sources. Whole frames are
//            granted round-robin and sent to the core as gap-free bursts of N
//            valid samples. Each launched frame's channel id goes into a tag
//            FIFO. The core's output stream is then labelled with that channel
//            and with start/end-of-frame markers.
// Ports    : clk, rst (async, active-low)
//            s0_*/s1_*       source request, sample valid, samples, ready
//            fft_x*/valid_in samples to the core (registered)
//            fft_y*/valid_out samples from the core
//            y*/y_valid/y_chan/y_sof/y_eof  labelled output (registered)
//            inflight        tag FIFO occupancy
//            err_underrun/err_orphan sticky flags, err_clr clears both
// Revision : 1.0 - initial release
// ============================================================================
module fft32_frame_sched #(
  parameter int DW        = 16,
  parameter int N         = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s0_req,
  input  logic                       s1_req,
  input  logic                       s0_valid,
  input  logic                       s1_valid,
  input  logic [DW-1:0]              s0_xr,
  input  logic [DW-1:0]              s0_xi,
  input  logic [DW-1:0]              s1_xr,
  input  logic [DW-1:0]              s1_xi,
  output logic                       s0_ready,
  output logic                       s1_ready,
  output logic [DW-1:0]              fft_xr,
  output logic [DW-1:0]              fft_xi,
  output logic                       fft_valid_in,
  input  logic [DW-1:0]              fft_yr,
  input  logic [DW-1:0]              fft_yi,
  input  logic                       fft_valid_out,
  output logic [DW-1:0]              yr,
  output logic [DW-1:0]              yi,
  output logic                       y_valid,
  output logic                       y_chan,
  output logic                       y_sof,
  output logic                       y_eof,
  output logic [$clog2(TAG_DEPTH):0] inflight,
  output logic                       err_underrun,
  output logic                       err_orphan,
  input  logic                       err_clr
);

  localparam int            CW       = $clog2(N);
  localparam int            PW       = $clog2(TAG_DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(N-1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(TAG_DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        in_cnt_q, in_cnt_d;
  logic                 last_q, last_d;
  logic                 gnt_ch_q, gnt_ch_d;
  logic [DW-1:0]        fft_xr_q, fft_xr_d, fft_xi_q, fft_xi_d;
  logic                 fft_valid_in_q, fft_valid_in_d;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;
  logic [TAG_DEPTH-1:0] tag_q, tag_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]          cnt_q, cnt_d;
  logic [DW-1:0]        yr_q, yr_d, yi_q, yi_d;
  logic                 y_valid_q, y_valid_d, y_chan_q, y_chan_d;
  logic                 y_sof_q, y_sof_d, y_eof_q, y_eof_d;
  logic                 err_underrun_q, err_underrun_d;
  logic                 err_orphan_q, err_orphan_d;

  logic decide, grant, grant_ch, in_burst, sel_valid, fifo_empty, push, pop;
  logic [DW-1:0] sel_xr, sel_xi;

  // Grant is evaluated when idle or in the final cycle of a burst, which is
  // what lets consecutive frames run back to back.
  always_comb begin
    in_burst = (state_q == ST_BURST);
    decide   = (state_q == ST_IDLE) || (in_burst && (in_cnt_q == LAST_IDX));
    grant    = decide && (s0_req || s1_req) && (cnt_q != FULL_CNT);
    // Tie goes to the channel that did not win last time.
    grant_ch = (s0_req && s1_req) ? ~last_q : s1_req;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (grant)                                 state_d = ST_BURST;
    else if (in_burst && in_cnt_q == LAST_IDX) state_d = ST_IDLE;
  end

  // FSM: outputs
  always_comb begin
    s0_ready = in_burst && !gnt_ch_q;
    s1_ready = in_burst &&  gnt_ch_q;
  end

  // Input datapath and tag FIFO
  always_comb begin
    sel_valid = gnt_ch_q ? s1_valid : s0_valid;
    sel_xr    = gnt_ch_q ? s1_xr    : s0_xr;
    sel_xi    = gnt_ch_q ? s1_xi    : s0_xi;

    in_cnt_d       = grant ? '0 : (in_burst ? in_cnt_q + 1'b1 : '0);
    last_d         = grant ? grant_ch : last_q;
    gnt_ch_d       = grant ? grant_ch : gnt_ch_q;
    fft_valid_in_d = in_burst;
    // A missing sample still occupies its slot so the burst stays contiguous.
    fft_xr_d       = (in_burst && sel_valid) ? sel_xr : '0;
    fft_xi_d       = (in_burst && sel_valid) ? sel_xi : '0;

    fifo_empty = (cnt_q == '0);
    push       = grant;
    pop        = fft_valid_out && (out_cnt_q == LAST_IDX) && !fifo_empty;
    tag_d      = tag_q;
    if (push) tag_d[wr_ptr_q] = grant_ch;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d      = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

    // Output labelling; out_cnt advances even on dropped orphan samples.
    out_cnt_d = fft_valid_out ? out_cnt_q + 1'b1 : out_cnt_q;
    y_valid_d = fft_valid_out && !fifo_empty;
    yr_d      = y_valid_d ? fft_yr : '0;
    yi_d      = y_valid_d ? fft_yi : '0;
    y_chan_d  = y_valid_d && tag_q[rd_ptr_q];
    y_sof_d   = y_valid_d && (out_cnt_q == '0);
    y_eof_d   = y_valid_d && (out_cnt_q == LAST_IDX);

    // An error event in the same cycle as err_clr keeps the flag set.
    err_underrun_d = (in_burst && !sel_valid) ? 1'b1 : (err_clr ? 1'b0 : err_underrun_q);
    err_orphan_d   = (fft_valid_out && fifo_empty) ? 1'b1 : (err_clr ? 1'b0 : err_orphan_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_q       <= '0;
      last_q         <= 1'b1;
      gnt_ch_q       <= 1'b0;
      fft_xr_q       <= '0;
      fft_xi_q       <= '0;
      fft_valid_in_q <= 1'b0;
      out_cnt_q      <= '0;
      tag_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      yr_q           <= '0;
      yi_q           <= '0;
      y_valid_q      <= 1'b0;
      y_chan_q       <= 1'b0;
      y_sof_q        <= 1'b0;
      y_eof_q        <= 1'b0;
      err_underrun_q <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      in_cnt_q       <= in_cnt_d;
      last_q         <= last_d;
      gnt_ch_q       <= gnt_ch_d;
      fft_xr_q       <= fft_xr_d;
      fft_xi_q       <= fft_xi_d;
      fft_valid_in_q <= fft_valid_in_d;
      out_cnt_q      <= out_cnt_d;
      tag_q          <= tag_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      yr_q           <= yr_d;
      yi_q           <= yi_d;
      y_valid_q      <= y_valid_d;
      y_chan_q       <= y_chan_d;
      y_sof_q        <= y_sof_d;
      y_eof_q        <= y_eof_d;
      err_underrun_q <= err_underrun_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  assign fft_xr       = fft_xr_q;
  assign fft_xi       = fft_xi_q;
  assign fft_valid_in = fft_valid_in_q;
  assign yr           = yr_q;
  assign yi           = yi_q;
  assign y_valid      = y_valid_q;
  assign y_chan       = y_chan_q;
  assign y_sof        = y_sof_q;
  assign y_eof        = y_eof_q;
  assign inflight     = cnt_q;
  assign err_underrun = err_underrun_q;
  assign err_orphan   = err_orphan_q;

endmodule
`default_nettype wire

// File: tb/tb_fft32_frame_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_fft32_frame_sched
// Purpose  : Self-checking bench for fft32_frame_sched. Two source models feed
//            frames, a delay-line stands in for the FFT core, and the observed
//            input/output streams are compared with streams built from the
//            round-robin frame rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft32_frame_sched;
  localparam int DW = 16, N = 32, TAG_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s0_req = 0, s1_req = 0, s0_valid = 0, s1_valid = 0, err_clr = 0;
  logic [DW-1:0] s0_xr = '0, s0_xi = '0, s1_xr = '0, s1_xi = '0;
  logic s0_ready, s1_ready, fft_valid_in, y_valid, y_chan, y_sof, y_eof;
  logic err_underrun, err_orphan;
  logic [DW-1:0] fft_xr, fft_xi, yr, yi;
  logic [$clog2(TAG_DEPTH):0] inflight;
  wire logic fft_valid_out;
  wire logic [DW-1:0] fft_yr, fft_yi;

  // core stand-in: delay line with selectable latency, or manual pulses
  logic core_en = 1'b0, man_v = 1'b0;
  logic [DW-1:0] man_r = '0;
  int lat = 3;
  logic pv [8];
  logic [DW-1:0] pr [8], pim [8];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pv[0] <= fft_valid_in; pr[0] <= fft_xr; pim[0] <= fft_xi;
    for (int k = 1; k < 8; k++) begin
      pv[k] <= pv[k-1]; pr[k] <= pr[k-1]; pim[k] <= pim[k-1];
    end
  end
  assign fft_valid_out = core_en ? pv[lat-1]  : man_v;
  assign fft_yr        = core_en ? pr[lat-1]  : man_r;
  assign fft_yi        = core_en ? pim[lat-1] : '0;

  fft32_frame_sched #(.DW(DW), .N(N), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s1_req(s1_req), .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_xr(s0_xr), .s0_xi(s0_xi), .s1_xr(s1_xr), .s1_xi(s1_xi),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .fft_xr(fft_xr), .fft_xi(fft_xi), .fft_valid_in(fft_valid_in),
    .fft_yr(fft_yr), .fft_yi(fft_yi), .fft_valid_out(fft_valid_out),
    .yr(yr), .yi(yi), .y_valid(y_valid), .y_chan(y_chan), .y_sof(y_sof), .y_eof(y_eof),
    .inflight(inflight), .err_underrun(err_underrun), .err_orphan(err_orphan),
    .err_clr(err_clr)
  );

  // ---------------- monitors ----------------
  typedef struct packed { logic chan, sof, eof; logic [DW-1:0] r, i; } ys_t;
  logic [2*DW-1:0] got_in[$];
  int              got_in_cyc[$];
  ys_t             got_y[$];
  int              cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (fft_valid_in === 1'b1) begin
      got_in.push_back({fft_xr, fft_xi});
      got_in_cyc.push_back(cyc);
    end
    if (y_valid === 1'b1) got_y.push_back({y_chan, y_sof, y_eof, yr, yi});
  end

  // ---------------- source models ----------------
  int  nfr[2], started[2], sidx[2];
  bit  active[2];
  bit  drop_map [2][4][N];
  bit  imp_g = 1'b0;
  int  nvec = 0, nmis = 0;

  function automatic void samp(input int c, input int f, input int i,
                               output logic [DW-1:0] r, output logic [DW-1:0] im);
    if (imp_g && c == 0) begin
      r  = (i == 0) ? 16'h7FFF : 16'h0000;
      im = '0;
    end else begin
      r  = DW'(c * 4096 + f * 512 + i * 7 + 3);
      im = DW'(16'hA000 ^ (c * 300 + f * 40 + i));
    end
  endfunction

  task automatic set_src(input int n0, input int n1);
    nfr[0] = n0; nfr[1] = n1;
    for (int c = 0; c < 2; c++) begin started[c] = 0; sidx[c] = 0; active[c] = 0; end
  endtask

  task automatic clear_drops();
    for (int c = 0; c < 2; c++)
      for (int f = 0; f < 4; f++)
        for (int i = 0; i < N; i++) drop_map[c][f][i] = 1'b0;
  endtask

  // Drive one cycle of source stimulus, clock it, then advance the sources
  // according to the ready they saw in that cycle.
  task automatic tick();
    bit r0, r1, sv[2], rq[2], rr[2];
    logic [DW-1:0] sr[2], si[2];
    for (int c = 0; c < 2; c++) begin
      int f, ix;
      f  = active[c] ? started[c] - 1 : started[c];
      ix = active[c] ? sidx[c] : 0;
      sv[c] = !((f < 4) && drop_map[c][f][ix]);
      samp(c, f, ix, sr[c], si[c]);
      rq[c] = (started[c] < nfr[c]);
    end
    s0_req = rq[0]; s1_req = rq[1]; s0_valid = sv[0]; s1_valid = sv[1];
    s0_xr = sr[0]; s0_xi = si[0]; s1_xr = sr[1]; s1_xi = si[1];
    r0 = (s0_ready === 1'b1); r1 = (s1_ready === 1'b1);
    @(posedge clk); #1;
    rr[0] = r0; rr[1] = r1;
    for (int c = 0; c < 2; c++) if (rr[c]) begin
      if (!active[c]) begin active[c] = 1; started[c]++; sidx[c] = 1; end
      else sidx[c]++;
      if (sidx[c] == N) begin active[c] = 0; sidx[c] = 0; end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0; err_clr = 0; man_v = 0;
    s0_req = 0; s1_req = 0; s0_valid = 0; s1_valid = 0;
    set_src(0, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Round-robin frame order with every frame already waiting after reset.
  function automatic bit [7:0] rr_order(input int n0, input int n1);
    int a[2]; int last; int k; bit [7:0] o;
    a[0] = n0; a[1] = n1; last = 1; k = 0; o = '0;
    while (a[0] + a[1] > 0) begin
      int c;
      if (a[0] > 0 && a[1] > 0) c = 1 - last;
      else                      c = (a[0] > 0) ? 0 : 1;
      o[k] = c[0]; k++; a[c]--; last = c;
    end
    return o;
  endfunction

  task automatic run_scen(input int n0, input int n1, input bit imp, input bit do_reset,
                          input bit [7:0] ord, input int maxinf_exp, input bit exp_ur,
                          input string tg);
    int nf, k, bound, maxinf, nbad, fc[2];
    logic [2*DW-1:0] exp_in[$];
    logic [DW-1:0] r, im;
    if (do_reset) apply_reset();
    imp_g = imp;
    got_in.delete(); got_in_cyc.delete(); got_y.delete();
    set_src(n0, n1);
    nf = n0 + n1; bound = nf * N + 80; k = 0; maxinf = 0;
    while (k < bound && !(got_y.size() >= nf * N && started[0] == n0 && started[1] == n1
                          && !active[0] && !active[1])) begin
      tick();
      if (int'(inflight) > maxinf) maxinf = int'(inflight);
      k++;
    end
    chk({tg, "_timeout"}, (k < bound), 1);
    fc[0] = 0; fc[1] = 0;
    for (int q = 0; q < nf; q++) begin
      int c, f;
      c = int'(ord[q]); f = fc[c]; fc[c]++;
      for (int i = 0; i < N; i++) begin
        samp(c, f, i, r, im);
        exp_in.push_back(drop_map[c][f][i] ? '0 : {r, im});
      end
    end
    chk({tg, "_in_count"}, got_in.size(), nf * N);
    nbad = 0;
    for (int j = 0; j < got_in.size() && j < nf * N; j++) if (got_in[j] !== exp_in[j]) nbad++;
    chk({tg, "_in_data_bad"}, nbad, 0);
    if (got_in_cyc.size() > 0)
      chk({tg, "_in_span"}, got_in_cyc[got_in_cyc.size()-1] - got_in_cyc[0] + 1, got_in.size());
    chk({tg, "_y_count"}, got_y.size(), nf * N);
    nbad = 0;
    for (int j = 0; j < got_y.size() && j < nf * N; j++) begin
      ys_t e;
      e.chan = ord[j / N]; e.sof = (j % N == 0); e.eof = (j % N == N - 1);
      {e.r, e.i} = exp_in[j];
      if (got_y[j] !== e) nbad++;
    end
    chk({tg, "_y_label_bad"}, nbad, 0);
    chk({tg, "_underrun"}, err_underrun, exp_ur);
    chk({tg, "_orphan"}, err_orphan, 0);
    chk({tg, "_inflight_end"}, inflight, 0);
    if (maxinf_exp >= 0) chk({tg, "_inflight_max"}, maxinf, maxinf_exp);
    if (exp_ur) begin
      err_clr = 1; tick(); err_clr = 0;
      chk({tg, "_underrun_clr"}, err_underrun, 0);
    end
  endtask

  typedef struct {
    int n0, n1; bit imp; int dch, df, di; bit [7:0] ord; int maxinf; bit ur;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, eof_at, rdy_cnt, n0, n1;
    bit [7:0] ord;
    bit ur;
    //        n0 n1 imp dch df di  ord           maxinf ur
    tbl[0] = '{1, 0, 1, -1, 0, 0,  8'b0000_0000, 1, 0};   // impulse
    tbl[1] = '{2, 2, 0, -1, 0, 0,  8'b0000_1010, 2, 0};   // 0,1,0,1
    tbl[2] = '{0, 1, 0,  1, 0, 5,  8'b0000_0001, 1, 1};   // s1 underrun at 5
    tbl[3] = '{1, 2, 0, -1, 0, 0,  8'b0000_0110, 2, 0};   // 0,1,1
    tbl[4] = '{3, 1, 0, -1, 0, 0,  8'b0000_0010, 2, 0};   // 0,1,0,0

    for (int k2 = 0; k2 < 8; k2++) begin pv[k2] = 0; pr[k2] = '0; pim[k2] = '0; end
    clear_drops();
    apply_reset();
    chk("rst_ready", {s0_ready, s1_ready}, 0);
    chk("rst_fft", {fft_valid_in, fft_xr, fft_xi}, 0);
    chk("rst_y", {y_valid, y_chan, y_sof, y_eof, yr, yi}, 0);
    chk("rst_err_inflight", {err_underrun, err_orphan, inflight}, 0);

    // table-driven frame scenarios
    core_en = 1; lat = 3;
    for (int v = 0; v < 5; v++) begin
      clear_drops();
      if (tbl[v].dch >= 0) drop_map[tbl[v].dch][tbl[v].df][tbl[v].di] = 1'b1;
      run_scen(tbl[v].n0, tbl[v].n1, tbl[v].imp, 1'b1, tbl[v].ord, tbl[v].maxinf,
               tbl[v].ur, $sformatf("vec%0d", v));
    end
    imp_g = 0;

    // randomized scenarios against the round-robin model
    for (int it = 0; it < 6; it++) begin
      n0 = $urandom_range(0, 3); n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      lat = $urandom_range(1, 8);
      clear_drops(); ur = 0;
      for (int c = 0; c < 2; c++)
        for (int f = 0; f < 4; f++)
          for (int i = 0; i < N; i++) begin
            drop_map[c][f][i] = ($urandom_range(0, 47) == 0);
            if (drop_map[c][f][i] && f < ((c == 0) ? n0 : n1)) ur = 1;
          end
      ord = rr_order(n0, n1);
      run_scen(n0, n1, 1'b0, 1'b1, ord, -1, ur, $sformatf("rnd%0d", it));
    end

    // full tag FIFO stalls the third frame until the first pop
    clear_drops(); lat = 3; core_en = 0; man_v = 0;
    apply_reset();
    got_in.delete(); got_in_cyc.delete(); got_y.delete();
    set_src(2, 1);
    k = 0;
    while (k < 300 && got_in.size() < 2 * N) begin tick(); k++; end
    chk("stall_two_bursts", got_in.size(), 2 * N);
    rdy_cnt = 0;
    repeat (20) begin tick(); if (s0_ready === 1'b1 || s1_ready === 1'b1) rdy_cnt++; end
    chk("stall_idle_ready", rdy_cnt, 0);
    chk("stall_inflight", inflight, 2);
    chk("stall_no_extra_in", got_in.size(), 2 * N);
    eof_at = -1;
    for (int c = 0; c < N + 4; c++) begin
      man_v = (c < N); man_r = DW'(c);
      tick();
      if (eof_at < 0 && y_eof === 1'b1) begin
        eof_at = c;
        chk("stall_ready_at_eof", s0_ready, 0);
        chk("stall_eof_chan", y_chan, 0);
        chk("stall_inflight_eof", inflight, 1);
      end else if (eof_at >= 0 && c == eof_at + 1) begin
        chk("stall_third_grant", s0_ready, 1);
      end
    end
    man_v = 0;
    chk("stall_eof_cycle", eof_at, N - 1);
    chk("stall_y_count", got_y.size(), N);

    // orphan outputs with an empty tag FIFO
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      man_v = 1; man_r = 16'h1234; tick();
      chk("orph_y_valid", y_valid, 0);
    end
    man_v = 0; tick();
    chk("orph_flag", err_orphan, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("orph_clr", err_orphan, 0);
    man_v = 1; err_clr = 1; tick(); man_v = 0; err_clr = 0;
    chk("orph_clr_same_cycle", err_orphan, 1);
    err_clr = 1; tick(); err_clr = 0;
    chk("orph_clr2", err_orphan, 0);
    chk("orph_inflight", inflight, 0);

    // reset in the middle of a burst
    clear_drops(); lat = 3; core_en = 1;
    apply_reset();
    set_src(1, 0);
    k = 0;
    while (k < 100 && !(active[0] && sidx[0] == 10)) begin tick(); k++; end
    chk("rstmid_reach", (k < 100), 1);
    chk("rstmid_pre_valid", fft_valid_in, 1);
    core_en = 0;
    rst = 1'b0; #1;
    chk("rstmid_ready", {s0_ready, s1_ready}, 0);
    chk("rstmid_fft", {fft_valid_in, fft_xr, fft_xi}, 0);
    chk("rstmid_y", {y_valid, y_chan, y_sof, y_eof, yr, yi}, 0);
    chk("rstmid_inflight", inflight, 0);
    set_src(0, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    core_en = 1;
    run_scen(1, 0, 1'b0, 1'b0, 8'b0, 1, 1'b0, "rstmid_new");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
`default_nettype wire
